// File: rtl/ram_copy_dma_if.sv
// RAM-side bus of the copy engine: registered read port plus write port,
// both on the shared clock. The engine is the master, the RAM the slave.
interface ram_copy_dma_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  re;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output re, rd_addr, we, wr_addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  re, rd_addr, we, wr_addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/ram_copy_dma.sv
// Word-by-word forward copy engine driving a dual-port RAM with a 1-cycle
// registered read. Each word costs one RD cycle and one WR cycle.
module ram_copy_dma #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_WIDTH-1:0]  src_addr,
    input  logic [ADDR_WIDTH-1:0]  dst_addr,
    input  logic [ADDR_WIDTH:0]    len,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [ADDR_WIDTH:0]    words_done,
    ram_copy_dma_if.master         mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  abort_flag;

    // cnt doubles as the visible words_done: it only advances on a WR edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            cnt        <= '0;
            abort_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt        <= '0;
                        abort_flag <= 1'b0;
                        if (len != '0) begin
                            src_q <= src_addr;
                            dst_q <= dst_addr;
                            len_q <= len;
                            state <= RD;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                RD: begin
                    if (abort) begin
                        abort_flag <= 1'b1;
                        state      <= FIN;
                    end else begin
                        state <= WR;
                    end
                end
                WR: begin
                    cnt <= cnt + 1'b1;
                    if (abort) begin
                        abort_flag <= 1'b1;
                        state      <= FIN;
                    end else if (cnt + 1'b1 == len_q) begin
                        state <= FIN;
                    end else begin
                        state <= RD;
                    end
                end
                FIN: begin
                    abort_flag <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state == RD) || (state == WR);
    assign done       = (state == FIN) && !abort_flag;
    assign aborted    = (state == FIN) && abort_flag;
    assign words_done = cnt;

    // NOTE: the write data is the RAM read port passed straight through, gated
    // to zero outside WR so no stale read word reaches the bus when idle.
    assign mem.re      = (state == RD);
    assign mem.rd_addr = (state == RD) ? src_q + cnt[ADDR_WIDTH-1:0] : '0;
    assign mem.we      = (state == WR);
    assign mem.wr_addr = (state == WR) ? dst_q + cnt[ADDR_WIDTH-1:0] : '0;
    assign mem.wr_data = (state == WR) ? mem.rd_data : '0;

endmodule

// File: tb/tb_ram_copy_dma.sv
// Bench for ram_copy_dma: a behavioural RAM, a per-copy cycle schedule built
// from the word-copy rules, and a negedge compare against that schedule.
module tb_ram_copy_dma;

    localparam int DW = 8;
    localparam int AW = 8;

    typedef struct packed {
        logic          re;
        logic [AW-1:0] rd_addr;
        logic          we;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          busy;
        logic          done;
        logic          aborted;
        logic [AW:0]   wd;
    } obs_t;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   len      = '0;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW:0]   words_done;

    ram_copy_dma_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem ();

    ram_copy_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .words_done (words_done),
        .mem        (mem.master)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i >= 16 && i < 20) return 8'hA0 + 8'(i - 16);
        return 8'(i) ^ 8'h5A;
    endfunction

    // Behavioural dual-port RAM, loaded on the first clock edge.
    logic [DW-1:0] ram [256];
    logic [DW-1:0] rd_q   = '0;
    logic          loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            loaded <= 1'b1;
        end else begin
            if (mem.we) ram[mem.wr_addr] <= mem.wr_data;
            if (mem.re) rd_q <= ram[mem.rd_addr];
        end
    end
    assign mem.rd_data = rd_q;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model state: expected RAM image and the per-cycle schedule of the current copy.
    logic [DW-1:0] ref_mem [256];
    obs_t          trace [1:600];
    int            trace_len   = 0;
    logic          trace_valid = 1'b0;
    int            k0          = 0;
    logic [AW:0]   last_wd     = '0;
    int            clk_cnt     = 0;

    int busy_cnt, done_cnt, aborted_cnt, re_cnt, we_cnt, done_cyc;

    always @(posedge clk) clk_cnt <= clk_cnt + 1;

    // Cycle c after the start edge: odd c reads word (c-1)/2, even c writes it,
    // then one completion cycle. An abort seen in cycle ab ends the copy at ab+1.
    function automatic void build_trace(input logic [AW-1:0] s, input logic [AW-1:0] d,
                                        input logic [AW:0] n, input int ab);
        logic [DW-1:0] shadow [256];
        obs_t          o;
        int            c;
        logic [AW:0]   written;
        bit            stop;
        logic [AW-1:0] ra, wa;
        shadow  = ref_mem;
        c       = 0;
        written = '0;
        stop    = 1'b0;
        for (int k = 0; k < int'(n) && !stop; k++) begin
            ra = s + 8'(k);
            wa = d + 8'(k);
            c++;
            o = '0; o.re = 1'b1; o.rd_addr = ra; o.busy = 1'b1; o.wd = written;
            trace[c] = o;
            if (ab == c) begin
                stop = 1'b1;
            end else begin
                c++;
                o = '0; o.we = 1'b1; o.wr_addr = wa; o.wr_data = shadow[ra];
                o.busy = 1'b1; o.wd = written;
                trace[c] = o;
                shadow[wa] = shadow[ra];
                written++;
                if (ab == c) stop = 1'b1;
            end
        end
        c++;
        o = '0; o.wd = written;
        if (stop) o.aborted = 1'b1; else o.done = 1'b1;
        trace[c]  = o;
        trace_len = c;
        last_wd   = written;
    endfunction

    // Single compare process: every cycle, DUT outputs against the schedule.
    always @(negedge clk) begin
        obs_t a, e;
        int   c;
        bit   in_job;
        a      = {mem.re, mem.rd_addr, mem.we, mem.wr_addr, mem.wr_data, busy, done, aborted, words_done};
        c      = clk_cnt - k0 + 1;
        in_job = rst_n && trace_valid && c >= 1 && c <= trace_len;
        e      = '0;
        if (in_job) e = trace[c];
        else if (rst_n) e.wd = last_wd;
        check($sformatf("cycle %0d outputs", c), {25'd0, a}, {25'd0, e});
        if (in_job && e.we) ref_mem[e.wr_addr] = e.wr_data;
        if (a.busy) busy_cnt++;
        if (a.done) begin done_cnt++; done_cyc = c; end
        if (a.aborted) aborted_cnt++;
        if (a.re) re_cnt++;
        if (a.we) we_cnt++;
    end

    // Called a little after a rising edge; returns 2 time units into cycle 1.
    task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW:0] n, input int ab);
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        @(posedge clk); #1;
        k0 = clk_cnt;
        build_trace(s, d, n, ab);
        trace_valid = 1'b1;
        busy_cnt = 0; done_cnt = 0; aborted_cnt = 0; re_cnt = 0; we_cnt = 0; done_cyc = -1;
        #1;
        start = 1'b0; src_addr = ~s; dst_addr = 8'h00; len = 9'd3;
    endtask

    task automatic wait_cycle(input int c);
        while (clk_cnt - k0 + 1 < c) begin @(posedge clk); #2; end
    endtask

    task automatic wait_end(input string name);
        int i;
        for (i = 0; i < 2000; i++) begin
            if (clk_cnt - k0 + 1 > trace_len) break;
            @(posedge clk); #2;
        end
        check({name, " timeout"}, 64'(i >= 2000), 64'd0);
    endtask

    initial begin
        int mism;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset words_done", 64'(words_done), 64'd0);
        check("reset busy/re/we", 64'({busy, mem.re, mem.we}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // abort while idle must be ignored
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        @(posedge clk); #2;

        // basic 4-word copy
        do_start(8'h10, 8'h80, 9'd4, 0);
        wait_end("copy4");
        check("copy4 mem80", 64'(ram[8'h80]), 64'hA0);
        check("copy4 mem81", 64'(ram[8'h81]), 64'hA1);
        check("copy4 mem82", 64'(ram[8'h82]), 64'hA2);
        check("copy4 mem83", 64'(ram[8'h83]), 64'hA3);
        check("copy4 done cycle", 64'(done_cyc), 64'd9);
        check("copy4 done pulses", 64'(done_cnt), 64'd1);
        check("copy4 busy cycles", 64'(busy_cnt), 64'd8);
        check("copy4 words_done", 64'(words_done), 64'd4);

        // zero-length copy
        do_start(8'h55, 8'h66, 9'd0, 0);
        wait_end("len0");
        check("len0 done cycle", 64'(done_cyc), 64'd1);
        check("len0 re/we count", 64'(re_cnt + we_cnt), 64'd0);
        check("len0 busy cycles", 64'(busy_cnt), 64'd0);
        check("len0 words_done", 64'(words_done), 64'd0);

        // source address wraps past 0xFF
        do_start(8'hFE, 8'h40, 9'd4, 0);
        wait_end("wrap");
        check("wrap mem40", 64'(ram[8'h40]), 64'hA4);
        check("wrap mem41", 64'(ram[8'h41]), 64'hA5);
        check("wrap mem42", 64'(ram[8'h42]), 64'h5A);
        check("wrap mem43", 64'(ram[8'h43]), 64'h5B);

        // abort during the third WR cycle (cycle 6)
        do_start(8'h00, 8'hC0, 9'd8, 6);
        wait_cycle(6);
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        wait_end("abort");
        check("abort words_done", 64'(words_done), 64'd3);
        check("abort pulses", 64'(aborted_cnt), 64'd1);
        check("abort done pulses", 64'(done_cnt), 64'd0);
        check("abort memC2", 64'(ram[8'hC2]), 64'h58);
        check("abort memC3 untouched", 64'(ram[8'hC3]), 64'h99);
        check("abort busy low", 64'(busy), 64'd0);

        // start re-pulsed while busy is ignored
        do_start(8'h10, 8'hA0, 9'd4, 0);
        wait_cycle(3);
        start = 1'b1; src_addr = 8'h00; len = 9'd2;
        @(posedge clk); #2;
        start = 1'b0;
        wait_end("restart");
        check("restart memA0", 64'(ram[8'hA0]), 64'hA0);
        check("restart memA3", 64'(ram[8'hA3]), 64'hA3);
        check("restart done cycle", 64'(done_cyc), 64'd9);

        // reset for one cycle while word 2 is being read
        do_start(8'h20, 8'h90, 9'd4, 0);
        wait_cycle(5);
        rst_n = 1'b0;
        #1;
        check("midreset outputs", 64'({busy, done, aborted, words_done, mem.re, mem.we,
                                       mem.rd_addr, mem.wr_addr, mem.wr_data}), 64'd0);
        trace_valid = 1'b0;
        last_wd     = '0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #2; end
        check("midreset mem90", 64'(ram[8'h90]), 64'h7A);
        check("midreset mem91", 64'(ram[8'h91]), 64'h7B);
        check("midreset mem92 untouched", 64'(ram[8'h92]), 64'hC8);

        // overlapping forward copy after reset: 0x30 smears into 0x31..0x33
        do_start(8'h30, 8'h31, 9'd3, 0);
        wait_end("overlap");
        check("overlap mem33", 64'(ram[8'h33]), 64'h6A);
        check("overlap done cycle", 64'(done_cyc), 64'd7);

        // whole-RAM copy
        do_start(8'h00, 8'h00, 9'd256, 0);
        wait_end("full");
        check("full words_done", 64'(words_done), 64'd256);
        check("full done cycle", 64'(done_cyc), 64'd513);

        mism = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) mism++;
        check("ram image mismatches", 64'(mism), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
